// File: rtl/ripeto_uart_pkg.sv
// Shared UART definitions: transmitter state encoding and line levels, reused by the future receiver.
package ripeto_uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    LOAD,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam logic TX_IDLE_LEVEL  = 1'b1;
  localparam logic TX_START_LEVEL = 1'b0;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts CLKS_PER_BIT clocks and emits a one-cycle bit_done tick at the end of each bit.
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic clock,
  input  logic reset,
  input  logic restart,
  output logic bit_done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clock) begin
    if (reset || restart) begin
      cnt <= '0;
    end else if (cnt == CNT_MAX) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign bit_done = !restart && (cnt == CNT_MAX);

endmodule

// File: rtl/fifo_uart_tx.sv
// FIFO-draining UART transmitter: pops one word per frame and sends it 8N1, LSB first.
// Define UART_TX_PARITY_EN to append an even-parity bit after the data bits.
module fifo_uart_tx
  import ripeto_uart_pkg::*;
#(
  parameter int DBITS        = 8,
  parameter int CLKS_PER_BIT = 868,
  parameter int RD_WAIT      = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             fifo_empty,
  input  logic [DBITS-1:0] fifo_dout,
  output logic             fifo_rd,
  output logic             tx,
  output logic             busy
);

  localparam int IW = $clog2(DBITS + 1);
  localparam int WW = $clog2(RD_WAIT + 1);
  localparam logic [IW-1:0] LAST_BIT  = IW'(DBITS - 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(RD_WAIT - 1);

  tx_state_t        state, state_d;
  logic [DBITS-1:0] shreg, shreg_d;
  logic [IW-1:0]    bidx, bidx_d;
  logic [WW-1:0]    wcnt, wcnt_d;
  logic             tx_d;
  logic             restart;
  logic             bit_done;
`ifdef UART_TX_PARITY_EN
  logic             par_q, par_d;
`endif

  // The bit timer only runs while a frame is on the line; LOAD restarts it so START gets a full bit.
  assign restart = !((state == START) || (state == DATA) ||
                     (state == PARITY) || (state == STOP));

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clock   (clock),
    .reset   (reset),
    .restart (restart),
    .bit_done(bit_done)
  );

  always_comb begin
    state_d = state;
    shreg_d = shreg;
    bidx_d  = bidx;
    wcnt_d  = wcnt;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    case (state)
      IDLE: begin
        if (enable && !fifo_empty) state_d = REQ;
      end
      REQ: begin
        wcnt_d  = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (wcnt == WAIT_LAST) state_d = LOAD;
        else                   wcnt_d  = wcnt + 1'b1;
      end
      LOAD: begin
        shreg_d = fifo_dout;
        bidx_d  = '0;
`ifdef UART_TX_PARITY_EN
        par_d   = ^fifo_dout;
`endif
        state_d = START;
      end
      START: begin
        if (bit_done) state_d = DATA;
      end
      DATA: begin
        if (bit_done) begin
          if (bidx == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            shreg_d = shreg >> 1;
            bidx_d  = bidx + 1'b1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_done) state_d = STOP;
      end
`endif
      STOP: begin
        if (bit_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Line level is decoded from the next state so tx switches on the same edge as the state.
    case (state_d)
      START:   tx_d = TX_START_LEVEL;
      DATA:    tx_d = shreg_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_d = par_d;
`endif
      default: tx_d = TX_IDLE_LEVEL;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      shreg   <= '0;
      bidx    <= '0;
      wcnt    <= '0;
      tx      <= TX_IDLE_LEVEL;
      fifo_rd <= 1'b0;
      busy    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state   <= state_d;
      shreg   <= shreg_d;
      bidx    <= bidx_d;
      wcnt    <= wcnt_d;
      tx      <= tx_d;
      fifo_rd <= (state_d == REQ);
      busy    <= (state_d != IDLE);
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

endmodule
